tl_a_arbiter2: RTL and testbench

- Two-requester TileLink-UL arbiter placed in front of the bus fragmenter on the peripheral path.
- Shares the fragmenter's single A channel between two masters using round-robin arbitration.
- Holds the grant for the full length of multi-beat bursts.
- Widens the source ID with a port bit and routes D-channel responses back to the owning master by that bit.

---
 rtl/tl_pkg.sv | 27 ++
 rtl/tl_rr_pick2.sv | 12 +
 rtl/tl_a_arbiter2.sv | 125 ++++++++++++
 tb/tb_tl_a_arbiter2.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants and beat-count helpers shared by the peripheral-path blocks.
package tl_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGIC       = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] INTENT      = 3'd5;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  function automatic logic has_data(input logic [2:0] opcode);
    return (opcode == PUT_FULL) || (opcode == PUT_PARTIAL);
  endfunction

  // A request without data, or one no larger than a bus beat, always occupies one beat.
  function automatic int unsigned num_beats(input logic [2:0] opcode, input int unsigned size,
                                            input int unsigned data_w);
    int unsigned beat_lg;
    beat_lg = $clog2(data_w / 8);
    if (!has_data(opcode) || size <= beat_lg) return 1;
    return 32'd1 << (size - beat_lg);
  endfunction

endpackage

// File: rtl/tl_rr_pick2.sv
// Two-way round-robin picker: ptr names the preferred requester; purely combinational.
module tl_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       grant_idx,
  output logic       any
);

  assign any       = |valid;
  assign grant_idx = valid[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/tl_a_arbiter2.sv
// Two-master TileLink-UL A-channel arbiter: zero-latency round-robin, grant held across bursts.
// Ready is passed straight through to the selected master; D responses are steered by source MSB.
module tl_a_arbiter2
  import tl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 4,
  parameter int SIZE_W = 3
) (
  input  logic                        clock,
  input  logic                        reset,

  input  logic [1:0]                  up_a_valid,
  output logic [1:0]                  up_a_ready,
  input  logic [1:0][2:0]             up_a_opcode,
  input  logic [1:0][2:0]             up_a_param,
  input  logic [1:0][SIZE_W-1:0]      up_a_size,
  input  logic [1:0][SRC_W-1:0]       up_a_source,
  input  logic [1:0][ADDR_W-1:0]      up_a_address,
  input  logic [1:0][DATA_W/8-1:0]    up_a_mask,
  input  logic [1:0][DATA_W-1:0]      up_a_data,

  output logic [1:0]                  up_d_valid,
  input  logic [1:0]                  up_d_ready,
  output logic [2:0]                  up_d_opcode,
  output logic [1:0]                  up_d_param,
  output logic [SIZE_W-1:0]           up_d_size,
  output logic [SRC_W-1:0]            up_d_source,
  output logic                        up_d_sink,
  output logic                        up_d_denied,
  output logic [DATA_W-1:0]           up_d_data,
  output logic                        up_d_corrupt,

  output logic                        dn_a_valid,
  input  logic                        dn_a_ready,
  output logic [2:0]                  dn_a_opcode,
  output logic [2:0]                  dn_a_param,
  output logic [SIZE_W-1:0]           dn_a_size,
  output logic [SRC_W:0]              dn_a_source,
  output logic [ADDR_W-1:0]           dn_a_address,
  output logic [DATA_W/8-1:0]         dn_a_mask,
  output logic [DATA_W-1:0]           dn_a_data,

  input  logic                        dn_d_valid,
  output logic                        dn_d_ready,
  input  logic [2:0]                  dn_d_opcode,
  input  logic [1:0]                  dn_d_param,
  input  logic [SIZE_W-1:0]           dn_d_size,
  input  logic [SRC_W:0]              dn_d_source,
  input  logic                        dn_d_sink,
  input  logic                        dn_d_denied,
  input  logic [DATA_W-1:0]           dn_d_data,
  input  logic                        dn_d_corrupt
);

  logic        locked;
  logic        owner;
  logic        rr_ptr;
  logic [15:0] beats_left;

  logic        grant_idx;
  logic        any;
  logic        sel;
  logic        fire;
  logic [15:0] first_beats;
  logic        d_port;

  tl_rr_pick2 u_pick (
    .valid     (up_a_valid),
    .ptr       (rr_ptr),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign sel         = locked ? owner : grant_idx;
  assign dn_a_valid  = ~reset & (locked ? up_a_valid[owner] : any);
  assign fire        = dn_a_valid & dn_a_ready;
  assign up_a_ready  = (dn_a_ready & ~reset) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign first_beats = 16'(num_beats(up_a_opcode[sel], 32'(up_a_size[sel]), DATA_W));

  assign dn_a_opcode  = up_a_opcode[sel];
  assign dn_a_param   = up_a_param[sel];
  assign dn_a_size    = up_a_size[sel];
  assign dn_a_source  = {sel, up_a_source[sel]};
  assign dn_a_address = up_a_address[sel];
  assign dn_a_mask    = up_a_mask[sel];
  assign dn_a_data    = up_a_data[sel];

  // The pointer moves only on a first beat so an in-flight burst never changes fairness order.
  always_ff @(posedge clock) begin
    if (reset) begin
      locked     <= 1'b0;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      beats_left <= '0;
    end else if (fire) begin
      if (!locked) begin
        rr_ptr <= ~sel;
        if (first_beats > 16'd1) begin
          locked     <= 1'b1;
          owner      <= sel;
          beats_left <= first_beats - 16'd1;
        end
      end else begin
        beats_left <= beats_left - 16'd1;
        if (beats_left == 16'd1) locked <= 1'b0;
      end
    end
  end

  // D responses ignore A lock state entirely.
  assign d_port       = dn_d_source[SRC_W];
  assign up_d_valid   = (dn_d_valid & ~reset) ? (d_port ? 2'b10 : 2'b01) : 2'b00;
  assign dn_d_ready   = up_d_ready[d_port] & ~reset;
  assign up_d_source  = dn_d_source[SRC_W-1:0];
  assign up_d_opcode  = dn_d_opcode;
  assign up_d_param   = dn_d_param;
  assign up_d_size    = dn_d_size;
  assign up_d_sink    = dn_d_sink;
  assign up_d_denied  = dn_d_denied;
  assign up_d_data    = dn_d_data;
  assign up_d_corrupt = dn_d_corrupt;

endmodule

// File: tb/tb_tl_a_arbiter2.sv
// Scenario tasks plus a randomized run, all checked against a burst-level model of the arbiter.
module tb_tl_a_arbiter2;
  import tl_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 4;
  localparam int SIZE_W = 3;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [1:0]               up_a_valid, up_a_ready;
  logic [1:0][2:0]          up_a_opcode, up_a_param;
  logic [1:0][SIZE_W-1:0]   up_a_size;
  logic [1:0][SRC_W-1:0]    up_a_source;
  logic [1:0][ADDR_W-1:0]   up_a_address;
  logic [1:0][DATA_W/8-1:0] up_a_mask;
  logic [1:0][DATA_W-1:0]   up_a_data;
  logic [1:0]               up_d_valid, up_d_ready;
  logic [2:0]               up_d_opcode;
  logic [1:0]               up_d_param;
  logic [SIZE_W-1:0]        up_d_size;
  logic [SRC_W-1:0]         up_d_source;
  logic                     up_d_sink, up_d_denied, up_d_corrupt;
  logic [DATA_W-1:0]        up_d_data;
  logic                     dn_a_valid, dn_a_ready;
  logic [2:0]               dn_a_opcode, dn_a_param;
  logic [SIZE_W-1:0]        dn_a_size;
  logic [SRC_W:0]           dn_a_source;
  logic [ADDR_W-1:0]        dn_a_address;
  logic [DATA_W/8-1:0]      dn_a_mask;
  logic [DATA_W-1:0]        dn_a_data;
  logic                     dn_d_valid, dn_d_ready;
  logic [2:0]               dn_d_opcode;
  logic [1:0]               dn_d_param;
  logic [SIZE_W-1:0]        dn_d_size;
  logic [SRC_W:0]           dn_d_source;
  logic                     dn_d_sink, dn_d_denied, dn_d_corrupt;
  logic [DATA_W-1:0]        dn_d_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who holds the bus for a burst, how many beats remain, and who has priority next.
  bit m_busy, m_holder, m_pri;
  int m_left;

  always #5 clock = ~clock;

  tl_a_arbiter2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W)) dut (
    .clock(clock), .reset(reset),
    .up_a_valid(up_a_valid), .up_a_ready(up_a_ready), .up_a_opcode(up_a_opcode),
    .up_a_param(up_a_param), .up_a_size(up_a_size), .up_a_source(up_a_source),
    .up_a_address(up_a_address), .up_a_mask(up_a_mask), .up_a_data(up_a_data),
    .up_d_valid(up_d_valid), .up_d_ready(up_d_ready), .up_d_opcode(up_d_opcode),
    .up_d_param(up_d_param), .up_d_size(up_d_size), .up_d_source(up_d_source),
    .up_d_sink(up_d_sink), .up_d_denied(up_d_denied), .up_d_data(up_d_data),
    .up_d_corrupt(up_d_corrupt),
    .dn_a_valid(dn_a_valid), .dn_a_ready(dn_a_ready), .dn_a_opcode(dn_a_opcode),
    .dn_a_param(dn_a_param), .dn_a_size(dn_a_size), .dn_a_source(dn_a_source),
    .dn_a_address(dn_a_address), .dn_a_mask(dn_a_mask), .dn_a_data(dn_a_data),
    .dn_d_valid(dn_d_valid), .dn_d_ready(dn_d_ready), .dn_d_opcode(dn_d_opcode),
    .dn_d_param(dn_d_param), .dn_d_size(dn_d_size), .dn_d_source(dn_d_source),
    .dn_d_sink(dn_d_sink), .dn_d_denied(dn_d_denied), .dn_d_data(dn_d_data),
    .dn_d_corrupt(dn_d_corrupt)
  );

  function automatic int ref_beats(input logic [2:0] op, input logic [2:0] sz);
    int bytes;
    bytes = 1 << sz;
    if (op == 3'd0 || op == 3'd1) return (bytes > DATA_W / 8) ? bytes / (DATA_W / 8) : 1;
    return 1;
  endfunction

  function automatic bit exp_sel();
    if (m_busy) return m_holder;
    if (up_a_valid[m_pri]) return m_pri;
    return !m_pri;
  endfunction

  function automatic bit exp_dn_valid();
    if (reset) return 1'b0;
    return m_busy ? up_a_valid[m_holder] : (up_a_valid != 2'b00);
  endfunction

  function automatic logic [1:0] exp_up_ready();
    if (reset || !dn_a_ready) return 2'b00;
    return exp_sel() ? 2'b10 : 2'b01;
  endfunction

  task automatic model_edge();
    bit s;
    int nb;
    if (reset) begin
      m_busy = 0; m_holder = 0; m_pri = 0; m_left = 0;
    end else if (exp_dn_valid() && dn_a_ready) begin
      s = exp_sel();
      if (!m_busy) begin
        m_pri = !s;
        nb = ref_beats(up_a_opcode[s], up_a_size[s]);
        if (nb > 1) begin
          m_busy = 1; m_holder = s; m_left = nb - 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src, input logic [31:0] addr);
    up_a_valid[i]   = v;
    up_a_opcode[i]  = op;
    up_a_param[i]   = 3'(i);
    up_a_size[i]    = sz;
    up_a_source[i]  = src;
    up_a_address[i] = addr;
    up_a_mask[i]    = 4'hf;
    up_a_data[i]    = addr ^ 32'hA5A5_0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1, GET, 3'd2, 4'd1, 32'h10);
    set_req(1, 1, GET, 3'd2, 4'd2, 32'h20);
    dn_a_ready = 1'b1; dn_d_valid = 1'b1; dn_d_source = 5'h10; up_d_ready = 2'b11;
    dn_d_opcode = ACCESS_ACK; dn_d_param = 2'd0; dn_d_size = 3'd2; dn_d_sink = 1'b0;
    dn_d_denied = 1'b0; dn_d_data = 32'h0; dn_d_corrupt = 1'b0;
    tick(); tick();
    n_cmp++; if (dn_a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dn_a_valid got=%b want=0", dn_a_valid); end
    n_cmp++; if (up_a_ready !== 2'b00) begin n_bad++; $display("FAIL reset_up_a_ready got=%b want=00", up_a_ready); end
    n_cmp++; if (up_d_valid !== 2'b00) begin n_bad++; $display("FAIL reset_up_d_valid got=%b want=00", up_d_valid); end
    reset = 1'b0; up_a_valid = 2'b00; dn_d_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_get();
    set_req(0, 1, GET, 3'd2, 4'd3, 32'h1000);
    set_req(1, 0, GET, 3'd2, 4'd9, 32'h1100);
    dn_a_ready = 1'b1;
    #1;
    n_cmp++; if (dn_a_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b want=1", dn_a_valid); end
    n_cmp++; if (dn_a_source !== 5'h03) begin n_bad++; $display("FAIL single_source got=%h want=03", dn_a_source); end
    n_cmp++; if (up_a_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready got=%b want=01", up_a_ready); end
    n_cmp++; if (dn_a_address !== 32'h1000) begin n_bad++; $display("FAIL single_addr got=%h want=1000", dn_a_address); end
    tick();
    // Both valid with no fire: the preferred requester must now be 1.
    up_a_valid = 2'b11; dn_a_ready = 1'b0;
    #1;
    n_cmp++; if (dn_a_source[SRC_W] !== 1'b1) begin n_bad++; $display("FAIL single_ptr_next got=%b want=1", dn_a_source[SRC_W]); end
    n_cmp++; if (up_a_ready !== 2'b00) begin n_bad++; $display("FAIL single_noready got=%b want=00", up_a_ready); end
    tick();
    up_a_valid = 2'b00;
  endtask

  task automatic test_alternate();
    int c0, c1;
    bit s;
    c0 = 0; c1 = 0;
    dn_a_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1, GET, 3'd2, 4'($urandom_range(0, 15)), $urandom);
      set_req(1, 1, GET, 3'd2, 4'($urandom_range(0, 15)), $urandom);
      #1;
      s = exp_sel();
      n_cmp++; if (up_a_ready !== (s ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL alt_ready cyc=%0d got=%b want_idx=%0d", k, up_a_ready, s); end
      n_cmp++; if (dn_a_source !== {s, up_a_source[s]}) begin n_bad++; $display("FAIL alt_source cyc=%0d got=%h want=%h", k, dn_a_source, {s, up_a_source[s]}); end
      if (up_a_ready[0]) c0++;
      if (up_a_ready[1]) c1++;
      tick();
    end
    n_cmp++; if (c0 != 4) begin n_bad++; $display("FAIL alt_count0 got=%0d want=4", c0); end
    n_cmp++; if (c1 != 4) begin n_bad++; $display("FAIL alt_count1 got=%0d want=4", c1); end
    up_a_valid = 2'b00;
  endtask

  task automatic test_burst();
    dn_a_ready = 1'b1;
    set_req(0, 1, GET, 3'd2, 4'd1, 32'h3000);
    set_req(1, 0, GET, 3'd2, 4'd5, 32'h2000);
    tick();
    set_req(1, 1, PUT_FULL, 3'd4, 4'd5, 32'h2000);
    for (int b = 0; b < 4; b++) begin
      up_a_data[1] = 32'hB000_0000 + 32'(b);
      #1;
      n_cmp++; if (up_a_ready !== 2'b10) begin n_bad++; $display("FAIL burst_ready beat=%0d got=%b want=10", b, up_a_ready); end
      n_cmp++; if (dn_a_source !== 5'h15) begin n_bad++; $display("FAIL burst_source beat=%0d got=%h want=15", b, dn_a_source); end
      n_cmp++; if (dn_a_data !== 32'hB000_0000 + 32'(b)) begin n_bad++; $display("FAIL burst_data beat=%0d got=%h", b, dn_a_data); end
      tick();
    end
    set_req(1, 1, GET, 3'd2, 4'd5, 32'h2100);
    #1;
    n_cmp++; if (up_a_ready !== 2'b01) begin n_bad++; $display("FAIL burst_after got=%b want=01", up_a_ready); end
    n_cmp++; if (dn_a_source !== 5'h01) begin n_bad++; $display("FAIL burst_after_src got=%h want=01", dn_a_source); end
    tick();
    up_a_valid = 2'b00;
  endtask

  task automatic test_d_routing();
    dn_d_valid = 1'b1; dn_d_source = 5'h12; up_d_ready = 2'b01; dn_d_data = 32'hCAFE_0012;
    #1;
    n_cmp++; if (up_d_valid !== 2'b10) begin n_bad++; $display("FAIL d_valid12 got=%b want=10", up_d_valid); end
    n_cmp++; if (up_d_source !== 4'h2) begin n_bad++; $display("FAIL d_source12 got=%h want=2", up_d_source); end
    n_cmp++; if (dn_d_ready !== 1'b0) begin n_bad++; $display("FAIL d_ready12_blocked got=%b want=0", dn_d_ready); end
    n_cmp++; if (up_d_data !== 32'hCAFE_0012) begin n_bad++; $display("FAIL d_data got=%h want=cafe0012", up_d_data); end
    up_d_ready = 2'b10;
    #1;
    n_cmp++; if (dn_d_ready !== 1'b1) begin n_bad++; $display("FAIL d_ready12 got=%b want=1", dn_d_ready); end
    dn_d_source = 5'h05; up_d_ready = 2'b01;
    #1;
    n_cmp++; if (up_d_valid !== 2'b01) begin n_bad++; $display("FAIL d_valid05 got=%b want=01", up_d_valid); end
    n_cmp++; if (dn_d_ready !== 1'b1) begin n_bad++; $display("FAIL d_ready05 got=%b want=1", dn_d_ready); end
    dn_d_valid = 1'b0;
    #1;
    n_cmp++; if (up_d_valid !== 2'b00) begin n_bad++; $display("FAIL d_idle got=%b want=00", up_d_valid); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    dn_a_ready = 1'b1;
    set_req(0, 1, PUT_FULL, 3'd4, 4'd2, 32'h4000);
    set_req(1, 0, GET, 3'd2, 4'd6, 32'h4100);
    for (int b = 0; b < 2; b++) begin
      #1;
      n_cmp++; if (up_a_ready !== 2'b01) begin n_bad++; $display("FAIL rmb_beat beat=%0d got=%b want=01", b, up_a_ready); end
      tick();
    end
    reset = 1'b1; dn_d_valid = 1'b1;
    #1;
    n_cmp++; if (dn_a_valid !== 1'b0) begin n_bad++; $display("FAIL rmb_valid got=%b want=0", dn_a_valid); end
    n_cmp++; if (up_a_ready !== 2'b00) begin n_bad++; $display("FAIL rmb_ready got=%b want=00", up_a_ready); end
    n_cmp++; if (up_d_valid !== 2'b00) begin n_bad++; $display("FAIL rmb_dvalid got=%b want=00", up_d_valid); end
    tick();
    reset = 1'b0; dn_d_valid = 1'b0; dn_a_ready = 1'b0;
    set_req(0, 1, GET, 3'd2, 4'd2, 32'h4200);
    set_req(1, 1, GET, 3'd2, 4'd6, 32'h4300);
    #1;
    n_cmp++; if (dn_a_source[SRC_W] !== 1'b0) begin n_bad++; $display("FAIL rmb_ptr got=%b want=0", dn_a_source[SRC_W]); end
    tick();
    up_a_valid = 2'b10;
    #1;
    n_cmp++; if (dn_a_valid !== 1'b1) begin n_bad++; $display("FAIL rmb_unlocked got=%b want=1", dn_a_valid); end
    tick();
    up_a_valid = 2'b01; dn_a_ready = 1'b1;
    #1;
    n_cmp++; if (up_a_ready !== 2'b01) begin n_bad++; $display("FAIL rmb_get_ready got=%b want=01", up_a_ready); end
    n_cmp++; if (dn_a_source !== 5'h02) begin n_bad++; $display("FAIL rmb_get_src got=%h want=02", dn_a_source); end
    tick();
    up_a_valid = 2'b00;
  endtask

  task automatic test_stall();
    int fired;
    fired = 0;
    set_req(1, 1, PUT_PARTIAL, 3'd4, 4'd7, 32'h5000);
    set_req(0, 1, GET, 3'd2, 4'd8, 32'h5100);
    up_a_data[1] = 32'hD000_0000;
    dn_a_ready = 1'b1;
    #1;
    n_cmp++; if (up_a_ready !== 2'b10) begin n_bad++; $display("FAIL stall_first got=%b want=10", up_a_ready); end
    if (dn_a_valid && dn_a_ready) fired++;
    tick();
    dn_a_ready = 1'b0;
    up_a_data[1] = 32'hD000_0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (up_a_ready !== 2'b00 || dn_a_valid !== 1'b1 || dn_a_source[SRC_W] !== 1'b1) begin
        n_bad++; $display("FAIL stall_hold cyc=%0d ready=%b valid=%b port=%b want 00/1/1", k, up_a_ready, dn_a_valid, dn_a_source[SRC_W]);
      end
      tick();
    end
    dn_a_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      up_a_data[1] = 32'hD000_0000 + 32'(b);
      #1;
      n_cmp++; if (up_a_ready !== 2'b10) begin n_bad++; $display("FAIL stall_resume beat=%0d got=%b want=10", b, up_a_ready); end
      n_cmp++; if (dn_a_data !== 32'hD000_0000 + 32'(b)) begin n_bad++; $display("FAIL stall_data beat=%0d got=%h", b, dn_a_data); end
      if (dn_a_valid && dn_a_ready) fired++;
      tick();
    end
    n_cmp++; if (fired != 4) begin n_bad++; $display("FAIL stall_beats got=%0d want=4", fired); end
    #1;
    n_cmp++; if (up_a_ready !== 2'b01) begin n_bad++; $display("FAIL stall_next got=%b want=01", up_a_ready); end
    tick();
    up_a_valid = 2'b00;
  endtask

  task automatic test_random();
    logic [2:0] ops [3];
    bit s;
    logic [1:0] exp_d;
    ops[0] = PUT_FULL; ops[1] = PUT_PARTIAL; ops[2] = GET;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++)
        set_req(i, $urandom_range(0, 3) != 0, ops[$urandom_range(0, 2)], 3'($urandom_range(0, 4)),
                4'($urandom_range(0, 15)), $urandom);
      dn_a_ready  = $urandom_range(0, 3) != 0;
      dn_d_valid  = $urandom_range(0, 1) != 0;
      dn_d_source = 5'($urandom_range(0, 31));
      up_d_ready  = 2'($urandom_range(0, 3));
      #1;
      s = exp_sel();
      exp_d = dn_d_valid ? (dn_d_source[SRC_W] ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++; if (dn_a_valid !== exp_dn_valid()) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", k, dn_a_valid, exp_dn_valid()); end
      n_cmp++; if (up_a_ready !== exp_up_ready()) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", k, up_a_ready, exp_up_ready()); end
      if (exp_dn_valid()) begin
        n_cmp++; if (dn_a_source !== {s, up_a_source[s]} || dn_a_address !== up_a_address[s]) begin
          n_bad++; $display("FAIL rnd_fields cyc=%0d src=%h addr=%h want src=%h addr=%h", k, dn_a_source, dn_a_address, {s, up_a_source[s]}, up_a_address[s]);
        end
      end
      n_cmp++; if (up_d_valid !== exp_d) begin n_bad++; $display("FAIL rnd_dvalid cyc=%0d got=%b want=%b", k, up_d_valid, exp_d); end
      n_cmp++; if (dn_d_ready !== up_d_ready[dn_d_source[SRC_W]]) begin n_bad++; $display("FAIL rnd_dready cyc=%0d got=%b want=%b", k, dn_d_ready, up_d_ready[dn_d_source[SRC_W]]); end
      tick();
    end
    up_a_valid = 2'b00; dn_d_valid = 1'b0;
  endtask

  initial begin
    m_busy = 0; m_holder = 0; m_pri = 0; m_left = 0;
    up_a_valid = 2'b00;
    @(posedge clock);
    #1;
    test_reset();
    test_single_get();
    test_alternate();
    test_burst();
    test_d_routing();
    test_reset_mid_burst();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
